// File: rtl/max6675_pkg.sv
// rtl/max6675_pkg.sv - shared types and default constants for the MAX6675 reader
package max6675_pkg;

  localparam int FRAME_BITS       = 16;
  localparam int DEF_SPI_HALF     = 13;
  localparam int DEF_CONV_CLKS    = 22_000_000;
  localparam int DEF_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    TX_HI,
    TX_LO,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/max6675_tempsnsr_uart_tx.sv
// rtl/max6675_tempsnsr_uart_tx.sv - 8N1 UART transmitter with back-to-back chaining
module uart_tx
  import max6675_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int              CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       data, data_next;
  logic             serial_next;
  logic             done_next;
  logic             bit_last;

  assign o_tx_active = (state != UART_IDLE);

  // State, bit timer and the registered serial line.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= UART_IDLE;
      cnt         <= '0;
      idx         <= '0;
      data        <= '0;
      o_tx_serial <= 1'b1;
      o_tx_done   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      data        <= data_next;
      o_tx_serial <= serial_next;
      o_tx_done   <= done_next;
    end
  end

  // Bit sequencing; i_tx_dv is taken when idle or in the last stop-bit
  // cycle, so a waiting byte starts right where the stop bit ends.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    data_next   = data;
    serial_next = o_tx_serial;
    done_next   = 1'b0;
    bit_last    = (cnt == CNT_LAST);
    case (state)
      UART_IDLE: begin
        serial_next = 1'b1;
        if (i_tx_dv) begin
          data_next   = i_tx_byte;
          cnt_next    = '0;
          state_next  = UART_START;
          serial_next = 1'b0;
        end
      end
      UART_START: begin
        if (bit_last) begin
          cnt_next    = '0;
          idx_next    = '0;
          state_next  = UART_DATA;
          serial_next = data[0];
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      UART_DATA: begin
        if (bit_last) begin
          cnt_next = '0;
          if (idx == 3'd7) begin
            state_next  = UART_STOP;
            serial_next = 1'b1;
          end else begin
            idx_next    = idx + 3'd1;
            data_next   = {1'b0, data[7:1]};
            serial_next = data[1];
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      UART_STOP: begin
        if (bit_last) begin
          cnt_next  = '0;
          done_next = 1'b1;
          if (i_tx_dv) begin
            data_next   = i_tx_byte;
            state_next  = UART_START;
            serial_next = 1'b0;
          end else begin
            state_next = UART_IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/max6675_tempsnsr.sv
// rtl/max6675_tempsnsr.sv - MAX6675 SPI reader forwarding raw frames over UART
module max6675_tempsnsr
  import max6675_pkg::*;
#(
  parameter int SPI_HALF     = DEF_SPI_HALF,
  parameter int CONV_CLKS    = DEF_CONV_CLKS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
)(
  input  logic i_clk,
  input  logic i_reset,
  output logic o_CS,
  output logic o_SPI_CLk,
  input  logic i_SPI_MISO,
  output logic o_tx_Serial
);

  localparam int HALF_W = cnt_width(SPI_HALF);
  localparam int WAIT_W = cnt_width(CONV_CLKS);
  localparam int BIT_W  = cnt_width(FRAME_BITS);

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SPI_HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  // Three cycles are absorbed by the done pulse, the WAIT entry and the
  // registered CS, so the CS fall lands CONV_CLKS after the stop bit ends.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CONV_CLKS > 3) ? CONV_CLKS - 3 : 0);

  state_t                state, state_next;
  logic [HALF_W-1:0]     half_cnt, half_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic                  sck_phase, phase_next;
  logic [WAIT_W-1:0]     wait_cnt, wait_next;
  logic [FRAME_BITS-1:0] shreg, shreg_next;
  logic [FRAME_BITS-1:0] frame, frame_next;
  logic                  hi_sent, hi_next;
  logic                  half_last;
  logic                  tx_dv;
  logic [7:0]            tx_byte;
  logic                  tx_done;
  logic                  tx_active;

  // State, counters and the CS/SCK pins, decoded from the current state
  // through a register so the pins never glitch.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= CS_SETUP;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      sck_phase <= 1'b0;
      wait_cnt  <= '0;
      shreg     <= '0;
      frame     <= '0;
      hi_sent   <= 1'b0;
      o_CS      <= 1'b1;
      o_SPI_CLk <= 1'b0;
    end else begin
      state     <= state_next;
      half_cnt  <= half_next;
      bit_cnt   <= bit_next;
      sck_phase <= phase_next;
      wait_cnt  <= wait_next;
      shreg     <= shreg_next;
      frame     <= frame_next;
      hi_sent   <= hi_next;
      o_CS      <= !((state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD));
      o_SPI_CLk <= (state == SHIFT) && sck_phase;
    end
  end

  // Frame sequencing: SPI read, two UART bytes, conversion wait.
  always_comb begin
    state_next = state;
    half_next  = half_cnt;
    bit_next   = bit_cnt;
    phase_next = sck_phase;
    wait_next  = wait_cnt;
    shreg_next = shreg;
    frame_next = frame;
    hi_next    = hi_sent;
    tx_dv      = 1'b0;
    tx_byte    = frame[15:8];
    half_last  = (half_cnt == HALF_LAST);
    case (state)
      CS_SETUP: begin
        if (half_last) begin
          half_next  = '0;
          bit_next   = '0;
          phase_next = 1'b1;
          state_next = SHIFT;
        end else begin
          half_next = half_cnt + HALF_W'(1);
        end
      end
      SHIFT: begin
        // Sample on the cycle SCK goes high; first sample is D15.
        if (sck_phase && (half_cnt == '0)) begin
          shreg_next = {shreg[FRAME_BITS-2:0], i_SPI_MISO};
        end
        if (half_last) begin
          half_next = '0;
          if (sck_phase) begin
            phase_next = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            state_next = CS_HOLD;
          end else begin
            phase_next = 1'b1;
            bit_next   = bit_cnt + BIT_W'(1);
          end
        end else begin
          half_next = half_cnt + HALF_W'(1);
        end
      end
      CS_HOLD: begin
        if (half_last) begin
          half_next  = '0;
          frame_next = shreg;
          hi_next    = 1'b0;
          state_next = TX_HI;
        end else begin
          half_next = half_cnt + HALF_W'(1);
        end
      end
      TX_HI: begin
        // High byte goes to the idle transmitter; the low byte is then held
        // valid so it chains onto the end of the high byte's stop bit.
        tx_dv   = 1'b1;
        tx_byte = hi_sent ? frame[7:0] : frame[15:8];
        if (!tx_active) begin
          hi_next = 1'b1;
        end
        if (tx_done) begin
          state_next = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_done) begin
          wait_next  = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          half_next  = '0;
          state_next = CS_SETUP;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_next = CS_SETUP;
    endcase
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_tx_dv     (tx_dv),
    .i_tx_byte   (tx_byte),
    .o_tx_serial (o_tx_Serial),
    .o_tx_active (tx_active),
    .o_tx_done   (tx_done)
  );

endmodule

// File: tb/tb_max6675_tempsnsr.sv
// tb/tb_max6675_tempsnsr.sv - directed bench for the MAX6675 reader
module tb_max6675_tempsnsr;

  localparam int HALF = 13;
  localparam int CONV = 2000;
  localparam int CPB  = 16;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic o_CS;
  logic o_SPI_CLk;
  logic i_SPI_MISO = 1'b0;
  logic o_tx_Serial;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_stop_end = 0;
  logic [15:0] miso_word = 16'h0000;
  int falls = 0;
  logic sck_prev = 1'b0;

  max6675_tempsnsr #(
    .SPI_HALF     (HALF),
    .CONV_CLKS    (CONV),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .o_CS        (o_CS),
    .o_SPI_CLk   (o_SPI_CLk),
    .i_SPI_MISO  (i_SPI_MISO),
    .o_tx_Serial (o_tx_Serial)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // MAX6675 model: D15 valid while CS is high, next bit after each SCK fall.
  always @(negedge i_clk) begin
    if (o_CS !== 1'b0) falls = 0;
    else if (sck_prev && !o_SPI_CLk) falls = falls + 1;
    sck_prev = o_SPI_CLk;
    i_SPI_MISO = (falls < 16) ? miso_word[4'(15 - falls)] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passes++;
  endtask

  task automatic spi_frame(input string tag, output int wait_c, output int fall_cyc);
    int low_c, pulses, hmin, hmax, gmin, gmax, lead, run;
    logic prev;
    wait_c = 0;
    while (o_CS !== 1'b0 && wait_c < 5000) begin
      @(negedge i_clk);
      wait_c++;
    end
    fall_cyc = cyc;
    low_c = 0; pulses = 0; hmin = 9999; hmax = 0; gmin = 9999; gmax = 0;
    lead = -1; run = 0; prev = 1'b0;
    while (o_CS === 1'b0 && low_c < 1000) begin
      low_c++;
      if (o_SPI_CLk !== prev) begin
        if (prev == 1'b0) begin
          if (pulses == 0) lead = run;
          else begin
            if (run < gmin) gmin = run;
            if (run > gmax) gmax = run;
          end
          pulses++;
        end else begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end
        run = 0;
      end
      run++;
      prev = o_SPI_CLk;
      @(negedge i_clk);
    end
    check({tag, " cs low cycles"}, 32'(low_c), 32'(HALF * 34));
    check({tag, " sck pulses"}, 32'(pulses), 16);
    check({tag, " cs to first sck"}, 32'(lead), 32'(HALF));
    check({tag, " sck high min"}, 32'(hmin), 32'(HALF));
    check({tag, " sck high max"}, 32'(hmax), 32'(HALF));
    check({tag, " sck low min"}, 32'(gmin), 32'(HALF));
    check({tag, " sck low max"}, 32'(gmax), 32'(HALF));
  endtask

  task automatic uart_rx(output logic [7:0] data, output logic stop_bit, output logic found,
                         output int start_cyc);
    int n;
    n = 0; data = 8'h00; stop_bit = 1'b0; found = 1'b0; start_cyc = 0;
    while (o_tx_Serial !== 1'b0 && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    if (o_tx_Serial === 1'b0) begin
      found = 1'b1;
      start_cyc = cyc;
      repeat (CPB / 2) @(negedge i_clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge i_clk);
        data[i] = o_tx_Serial;
      end
      repeat (CPB) @(negedge i_clk);
      stop_bit = o_tx_Serial;
    end
  endtask

  task automatic rx_frame(input string tag, input logic [15:0] expw);
    logic [7:0] b;
    logic sb, f;
    int s0, s1;
    uart_rx(b, sb, f, s0);
    check({tag, " hi start seen"}, 32'(f), 1);
    check({tag, " hi byte"}, 32'(b), 32'(expw[15:8]));
    check({tag, " hi stop bit"}, 32'(sb), 1);
    uart_rx(b, sb, f, s1);
    check({tag, " lo start seen"}, 32'(f), 1);
    check({tag, " lo byte"}, 32'(b), 32'(expw[7:0]));
    check({tag, " lo stop bit"}, 32'(sb), 1);
    check({tag, " byte spacing"}, 32'(s1 - s0), 32'(10 * CPB));
    last_stop_end = s1 + 10 * CPB;
  endtask

  initial begin
    int viol, w, fc, n;
    viol = 0;
    miso_word = 16'h1234;
    repeat (100) begin
      @(negedge i_clk);
      if (o_CS !== 1'b1 || o_SPI_CLk !== 1'b0 || o_tx_Serial !== 1'b1) viol++;
    end
    check("reset idle violations", 32'(viol), 0);
    check("reset cs", 32'(o_CS), 1);
    check("reset sck", 32'(o_SPI_CLk), 0);
    check("reset tx", 32'(o_tx_Serial), 1);

    i_reset = 1'b1;
    spi_frame("f1", w, fc);
    check("f1 cs fall delay", 32'(w), 1);
    rx_frame("f1", 16'h1234);

    miso_word = 16'h5555;
    spi_frame("f2", w, fc);
    check("f2 conversion gap", 32'(fc - last_stop_end >= CONV - 1 && fc - last_stop_end <= CONV + 1), 1);
    rx_frame("f2", 16'h5555);

    miso_word = 16'hAAAA;
    spi_frame("f3", w, fc);
    rx_frame("f3", 16'hAAAA);

    // Abort a frame in the middle of SHIFT.
    miso_word = 16'h0F3C;
    n = 0;
    while (o_CS !== 1'b0 && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    check("f4 cs fall seen", 32'(o_CS), 0);
    repeat (100) @(negedge i_clk);
    check("f4 sck high before reset", 32'(o_SPI_CLk), 1);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("shift reset cs", 32'(o_CS), 1);
    check("shift reset sck", 32'(o_SPI_CLk), 0);
    check("shift reset tx", 32'(o_tx_Serial), 1);
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    spi_frame("f5", w, fc);
    check("f5 cs fall delay", 32'(w), 1);
    rx_frame("f5", 16'h0F3C);

    // Abort the high byte in the middle of its data bits (bit 2 of 0xC3 is 0).
    miso_word = 16'hC3A5;
    spi_frame("f6", w, fc);
    repeat (55) @(negedge i_clk);
    check("f6 tx low before reset", 32'(o_tx_Serial), 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("tx reset tx", 32'(o_tx_Serial), 1);
    check("tx reset cs", 32'(o_CS), 1);
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    spi_frame("f7", w, fc);
    check("f7 cs fall delay", 32'(w), 1);
    rx_frame("f7", 16'hC3A5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
